// File: rtl/ram_1r1w_clr_pkg.sv
// Shared types, default parameters and the lane-merge helper for the 1R1W clearable RAM.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int unsigned RAM_D_WIDTH_DEF    = 16;
  localparam int unsigned RAM_LANE_WIDTH_DEF = 8;
  localparam int unsigned RAM_A_WIDTH_DEF    = 4;
  localparam logic [RAM_D_WIDTH_DEF-1:0] RAM_INIT_VALUE_DEF = '0;

  // Widest word the merge helper handles; callers zero-extend and truncate around it.
  localparam int unsigned RAM_MAX_W = 256;

  function automatic logic [RAM_MAX_W-1:0] lane_merge(
    input logic [RAM_MAX_W-1:0] old_word,
    input logic [RAM_MAX_W-1:0] new_word,
    input logic [RAM_MAX_W-1:0] mask,
    input int unsigned          lane_w
  );
    logic [RAM_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < RAM_MAX_W; i++) begin
      if (mask[8'(i / lane_w)]) merged[8'(i)] = new_word[8'(i)];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_1r1w_clr_if.sv
// Access bus of the clearable RAM: clear request/status, write port and registered read port.
interface ram_1r1w_clr_if #(
  parameter int unsigned D_WIDTH    = 16,
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned A_WIDTH    = 4
);
  localparam int unsigned LANES = D_WIDTH / LANE_WIDTH;

  logic               init_req;
  logic               busy;
  logic               write_enable;
  logic [A_WIDTH-1:0] address_write;
  logic [D_WIDTH-1:0] data_write;
  logic [LANES-1:0]   lane_enable;
  logic               read_enable;
  logic [A_WIDTH-1:0] address_read;
  logic [D_WIDTH-1:0] data_read;
  logic               read_valid;

  modport master (
    output init_req, write_enable, address_write, data_write, lane_enable,
           read_enable, address_read,
    input  busy, data_read, read_valid
  );

  modport slave (
    input  init_req, write_enable, address_write, data_write, lane_enable,
           read_enable, address_read,
    output busy, data_read, read_valid
  );
endinterface

// File: rtl/ram_1r1w_clr_clear_ctrl.sv
// Clear engine: walks every address once writing INIT_VALUE, then idles in READY until init_req.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned        A_WIDTH    = RAM_A_WIDTH_DEF,
  parameter int unsigned        D_WIDTH    = RAM_D_WIDTH_DEF,
  parameter logic [D_WIDTH-1:0] INIT_VALUE = D_WIDTH'(RAM_INIT_VALUE_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_req,
  output logic               busy,
  output logic               clr_we,
  output logic [A_WIDTH-1:0] clr_addr,
  output logic [D_WIDTH-1:0] clr_data
);

  ram_state_e         state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b1;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (&cnt_q) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + A_WIDTH'(1);
        end
      end
      READY: begin
        busy = 1'b0;
        if (init_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_addr = cnt_q;
  assign clr_data = INIT_VALUE;

endmodule

// File: rtl/ram_1r1w_clr.sv
// Single-clock 1R1W RAM with lane write masks, registered read and hardware clear.
// Optional macro RAM_FWD_EN: same-address read/write returns the merged new word.
module ram_1r1w_clr
  import ram_pkg::*;
#(
  parameter int unsigned        D_WIDTH    = RAM_D_WIDTH_DEF,
  parameter int unsigned        LANE_WIDTH = RAM_LANE_WIDTH_DEF,
  parameter int unsigned        A_WIDTH    = RAM_A_WIDTH_DEF,
  parameter logic [D_WIDTH-1:0] INIT_VALUE = D_WIDTH'(RAM_INIT_VALUE_DEF)
) (
  input logic            clk,
  input logic            rst_n,
  ram_1r1w_clr_if.slave  bus
);

  localparam int unsigned A_MAX = 2 ** A_WIDTH;
  localparam int unsigned LANES = D_WIDTH / LANE_WIDTH;

  if (D_WIDTH % LANE_WIDTH != 0) begin : g_lane_chk
    $error("ram_1r1w_clr: D_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (D_WIDTH > RAM_MAX_W) begin : g_width_chk
    $error("ram_1r1w_clr: D_WIDTH exceeds lane_merge capacity");
  end

  logic               busy;
  logic               clr_we;
  logic [A_WIDTH-1:0] clr_addr;
  logic [D_WIDTH-1:0] clr_data;

  ram_clear_ctrl #(
    .A_WIDTH    (A_WIDTH),
    .D_WIDTH    (D_WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (bus.init_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_data (clr_data)
  );

  // init_req takes priority: user traffic in that cycle is discarded.
  logic user_we, user_re;
  assign user_we = ~busy & ~bus.init_req & bus.write_enable & (|bus.lane_enable);
  assign user_re = ~busy & ~bus.init_req & bus.read_enable;

  logic [D_WIDTH-1:0] mem [A_MAX];
  logic [D_WIDTH-1:0] wr_merged_p0;
  logic [D_WIDTH-1:0] rd_word_p0;

  assign wr_merged_p0 = D_WIDTH'(lane_merge(RAM_MAX_W'(mem[bus.address_write]),
                                            RAM_MAX_W'(bus.data_write),
                                            RAM_MAX_W'(bus.lane_enable),
                                            LANE_WIDTH));

`ifdef RAM_FWD_EN
  assign rd_word_p0 = (user_we && (bus.address_write == bus.address_read)) ? wr_merged_p0
                                                                          : mem[bus.address_read];
`else
  assign rd_word_p0 = mem[bus.address_read];
`endif

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= clr_data;
    end else if (user_we) begin
      mem[bus.address_write] <= wr_merged_p0;
    end
  end

  // p0 -> p1: registered read port
  logic               rd_vld_p1;
  logic [D_WIDTH-1:0] rd_data_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      rd_vld_p1 <= user_re;
      if (user_re) rd_data_p1 <= rd_word_p0;
    end
  end

  assign bus.busy       = busy;
  assign bus.read_valid = rd_vld_p1;
  assign bus.data_read  = rd_data_p1;

  logic unused_lanes;
  assign unused_lanes = (LANES == 0);

endmodule

// File: tb/tb_ram_1r1w_clr.sv
// Self-checking bench for ram_1r1w_clr: directed table, clear/reset corner sequences, random traffic.
module tb_ram_1r1w_clr;

  localparam int unsigned DW    = 16;
  localparam int unsigned LW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [15:0] INIT  = 16'hA5A5;
`ifdef RAM_FWD_EN
  localparam logic [15:0] COLL_EXP = 16'hBEEF;
`else
  localparam logic [15:0] COLL_EXP = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_1r1w_clr_if #(.D_WIDTH(DW), .LANE_WIDTH(LW), .A_WIDTH(AW)) bus ();

  ram_1r1w_clr #(
    .D_WIDTH    (DW),
    .LANE_WIDTH (LW),
    .A_WIDTH    (AW),
    .INIT_VALUE (INIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  aw;
    logic [15:0] dw;
    logic [1:0]  le;
    logic        re;
    logic [3:0]  ar;
    logic        vld;
    logic [15:0] dat;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model [DEPTH];
  logic [15:0] last_data;
  vec_t        tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] le);
    logic [15:0] r;
    r = old_w;
    for (int l = 0; l < 2; l++)
      if (le[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  task automatic fill_model();
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;
  endtask

  task automatic drive(input logic init, input logic we, input logic [3:0] aw,
                       input logic [15:0] dw, input logic [1:0] le,
                       input logic re, input logic [3:0] ar);
    bus.init_req      = init;
    bus.write_enable  = we;
    bus.address_write = aw;
    bus.data_write    = dw;
    bus.lane_enable   = le;
    bus.read_enable   = re;
    bus.address_read  = ar;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
  endtask

  // One READY-state cycle: drive, clock, compare, then commit the write to the model.
  task automatic apply(input string name, input logic we, input logic [3:0] aw,
                       input logic [15:0] dw, input logic [1:0] le, input logic re,
                       input logic [3:0] ar, input logic exp_vld, input logic [15:0] exp_dat);
    drive(1'b0, we, aw, dw, le, re, ar);
    tick();
    chk({name, "_vld"}, {31'd0, bus.read_valid}, {31'd0, exp_vld});
    chk({name, "_data"}, {16'd0, bus.data_read}, {16'd0, exp_dat});
    if (we && le != 2'b00) model[aw] = merge(model[aw], dw, le);
    if (exp_vld) last_data = exp_dat;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.busy && n < 100);
    chk(name, n, 16);
  endtask

  initial begin
    logic        we, re;
    logic [3:0]  aw, ar;
    logic [15:0] dw, exp;
    logic [1:0]  le;
    int          n;

    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd1);
    chk("rst_vld", {31'd0, bus.read_valid}, 32'd0);
    chk("rst_data", {16'd0, bus.data_read}, 32'd0);

    rst_n = 1'b1;
    count_busy("reset_clear_len");
    fill_model();
    last_data = 16'h0000;

    for (int i = 0; i < DEPTH; i++)
      apply("init_read", 1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'(i), 1'b1, INIT);

    tbl[0] = '{1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0, 1'b0, 16'hA5A5};
    tbl[1] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 16'hA534};
    tbl[2] = '{1'b1, 4'd7, 16'h0000, 2'b11, 1'b0, 4'd0, 1'b0, 16'hA534};
    tbl[3] = '{1'b1, 4'd7, 16'hBEEF, 2'b11, 1'b1, 4'd7, 1'b1, COLL_EXP};
    tbl[4] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7, 1'b1, 16'hBEEF};
    tbl[5] = '{1'b1, 4'd9, 16'h1234, 2'b00, 1'b1, 4'd9, 1'b1, 16'hA5A5};
    tbl[6] = '{1'b1, 4'd9, 16'hCAFE, 2'b10, 1'b1, 4'd0, 1'b1, 16'hA5A5};
    tbl[7] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd9, 1'b1, 16'hCAA5};
    tbl[8] = '{1'b1, 4'd0, 16'h0F0F, 2'b11, 1'b1, 4'd9, 1'b1, 16'hCAA5};
    tbl[9] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd0, 1'b1, 16'h0F0F};
    for (int i = 0; i < 10; i++)
      apply($sformatf("tbl%0d", i), tbl[i].we, tbl[i].aw, tbl[i].dw, tbl[i].le,
            tbl[i].re, tbl[i].ar, tbl[i].vld, tbl[i].dat);

    // init_req with a same-cycle write/read, then traffic while busy
    apply("pre5", 1'b1, 4'd5, 16'h0000, 2'b11, 1'b0, 4'd0, 1'b0, last_data);
    drive(1'b1, 1'b1, 4'd2, 16'h5555, 2'b11, 1'b1, 4'd5);
    tick();
    chk("init_busy_rise", {31'd0, bus.busy}, 32'd1);
    chk("init_drop_vld", {31'd0, bus.read_valid}, 32'd0);
    chk("init_hold_data", {16'd0, bus.data_read}, {16'd0, last_data});
    drive(1'b0, 1'b1, 4'd5, 16'hFFFF, 2'b11, 1'b1, 4'd5);
    n = 0;
    do begin
      tick();
      n++;
      chk("busy_read_drop", {31'd0, bus.read_valid}, 32'd0);
    end while (bus.busy && n < 100);
    chk("init_clear_len", n, 16);
    idle();
    fill_model();
    apply("clr_addr2", 1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd2, 1'b1, INIT);
    apply("clr_addr5", 1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd5, 1'b1, INIT);

    // reset landing at clear count 9
    drive(1'b1, 1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
    tick();
    idle();
    repeat (9) tick();
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    repeat (2) tick();
    chk("mid_rst_data", {16'd0, bus.data_read}, 32'd0);
    chk("mid_rst_vld", {31'd0, bus.read_valid}, 32'd0);
    rst_n = 1'b1;
    count_busy("mid_rst_clear_len");
    chk("post_rst_data", {16'd0, bus.data_read}, 32'd0);
    chk("post_rst_vld", {31'd0, bus.read_valid}, 32'd0);
    fill_model();
    last_data = 16'h0000;

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      re = 1'($urandom);
      aw = 4'($urandom_range(0, 15));
      ar = ($urandom_range(0, 3) == 0) ? aw : 4'($urandom_range(0, 15));
      dw = 16'($urandom);
      le = 2'($urandom);
      exp = model[ar];
`ifdef RAM_FWD_EN
      if (we && aw == ar) exp = merge(model[ar], dw, le);
`endif
      if (!re) exp = last_data;
      apply("rand", we, aw, dw, le, re, ar, re, exp);
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
